imm_fmt_issue_ctrl: RTL
=======================

Name: imm_fmt_issue_ctrl

Overview:
- Stage-2 (decode) issue controller in front of the immediate generator.
- Accepts fetched instructions over a valid/ready handshake and holds each one in an output register.
- Classifies each instruction into the one-hot format flags that drive the immediate mux-select logic.
- Inserts a one-cycle bubble on load-use hazards against the instruction currently being issued, and supports pipeline flush.

Parameters:
- CNT_W, 16, width of the bubble counter. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop the held instruction and block input this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  controller accepts the instruction this cycle
- in_instr  in  32  fetched instruction
- out_valid  out  1  held instruction is valid
- out_ready  in  1  execute stage accepts the held instruction
- out_instr  out  32  held instruction
- Rformat, Iformat, IbutnotSRAIformat, Sformat, SBformat, Uformat, UJformat  out  1 each  registered format flags of out_instr
- illegal  out  1  held opcode is not one of the recognised formats
- bubble_cnt  out  CNT_W  bubbles inserted (present only with STALL_CNT_EN)

Behaviour:
- Reset, asynchronous: state=EMPTY; out_valid=0; out_instr=0; all format flags=0; illegal=0; bubble_cnt=0.
- Opcode decode on in_instr[6:0], registered together with the instruction:
  - R: 0110011
  - I: 0010011, 0000011, 1100111
  - IbutnotSRAI: I, except opcode 0010011 with funct3 = 101
  - S: 0100011
  - SB: 1100011
  - U: 0110111, 0010111
  - UJ: 1101111
  - Any other opcode: all flags 0, illegal=1
- Register usage:
  - rs1 = instr[19:15], used by R, I, S, SB.
  - rs2 = instr[24:20], used by R, S, SB.
- Hazard (combinational), all of the following true:
  - out_valid
  - held opcode = 0000011
  - held rd = instr[11:7], and held rd ≠ 0
  - in_valid
  - incoming rs1 or rs2 is used and equals held rd
- in_ready = ~flush & (~out_valid | out_ready) & ~hazard.
- FSM states: EMPTY, FULL, BUBBLE. out_valid = (state == FULL). BUBBLE behaves like EMPTY for the handshake and lasts exactly one cycle.
- EMPTY/BUBBLE:
  - in_valid & in_ready → load register, go to FULL.
  - Otherwise go to EMPTY.
- FULL:
  - out_ready & hazard → go to BUBBLE. Register not loaded; bubble_cnt increments.
  - out_ready & in_valid & ~hazard → load the next instruction back-to-back, stay FULL (zero-bubble throughput).
  - out_ready & ~in_valid → go to EMPTY.
  - ~out_ready → hold the register and all flags stable.
- flush has priority over everything:
  - Next state EMPTY, out_valid=0 next cycle.
  - Input that cycle is not accepted (in_ready=0).
  - A pending bubble is cancelled; bubble_cnt does not increment.
- Latency: an accepted instruction appears on out_* the next cycle.
- When out_valid=0, out_instr and the flags keep their last value; consumers must qualify with out_valid.
- Reset asserted mid-operation returns to the reset values immediately; any held instruction is lost.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: bubble_cnt port exists. CNT_W-bit counter increments on each FULL→BUBBLE transition, wraps from all-ones to 0, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back issue: lw x5,0(x1)=0x0000A283, then add x6,x5,x2=0x00228333, out_ready=1 → lw issued with Iformat=1. Next cycle out_valid=0 (BUBBLE), then add issued with Rformat=1; bubble_cnt=1.
- Independent instruction after load: lw 0x0000A283, then add x6,x3,x2=0x00218333 → no bubble, consecutive out_valid cycles, bubble_cnt=0.
- Format decode:
  - srai x7,x7,3=0x4033D393 → Iformat=1, IbutnotSRAIformat=0.
  - lui 0x123450B7 → Uformat=1.
  - jal 0x0000006F → UJformat=1.
  - 0xFFFFFFFF → illegal=1, all flags 0.
- Backpressure: hold out_ready=0 for 3 cycles while FULL → in_ready=0, out_instr and flags unchanged. Release → next instruction loads the following cycle.
- Flush during hazard: held lw 0x0000A283, dependent add offered, flush=1 with out_ready=1 → next cycle EMPTY, in_ready was 0, bubble_cnt unchanged. The add is accepted after flush deasserts.
- Reset mid-FULL: assert rst asynchronously between clock edges → out_valid=0 and flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/imm_fmt_issue_ctrl.sv
// Decode-stage issue controller: holds one instruction, registers its immediate-format
// flags, and inserts a one-cycle bubble on load-use hazards. Optional macro: STALL_CNT_EN.
module imm_fmt_issue_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             Rformat,
   output logic             Iformat,
   output logic             IbutnotSRAIformat,
   output logic             Sformat,
   output logic             SBformat,
   output logic             Uformat,
   output logic             UJformat,
   output logic             illegal
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] instr_q;
   // Flag order: {R, I, IbutnotSRAI, S, SB, U, UJ, illegal}
   logic [7:0]  fmt_q, fmt_d;

   logic [6:0]  in_op;
   logic [2:0]  in_funct3;
   logic        uses_rs1, uses_rs2;
   logic        held_is_load;
   logic [4:0]  held_rd;
   logic        hazard;
   logic        load;

   assign in_op     = in_instr[6:0];
   assign in_funct3 = in_instr[14:12];

   always_comb begin
      fmt_d = 8'b0;
      unique case (in_op)
         7'b0110011: fmt_d[7] = 1'b1;
         7'b0010011: begin
            fmt_d[6] = 1'b1;
            fmt_d[5] = (in_funct3 != 3'b101);
         end
         7'b0000011,
         7'b1100111: fmt_d[6:5] = 2'b11;
         7'b0100011: fmt_d[4] = 1'b1;
         7'b1100011: fmt_d[3] = 1'b1;
         7'b0110111,
         7'b0010111: fmt_d[2] = 1'b1;
         7'b1101111: fmt_d[1] = 1'b1;
         default:    fmt_d[0] = 1'b1;
      endcase
   end

   assign uses_rs1 = fmt_d[7] | fmt_d[6] | fmt_d[4] | fmt_d[3];
   assign uses_rs2 = fmt_d[7] | fmt_d[4] | fmt_d[3];

   // Load-use check is made against the instruction currently sitting on out_*.
   assign held_is_load = (instr_q[6:0] == 7'b0000011);
   assign held_rd      = instr_q[11:7];
   assign out_valid    = (state_q == FULL);

   assign hazard = out_valid & held_is_load & (held_rd != 5'd0) & in_valid &
                   ((uses_rs1 & (in_instr[19:15] == held_rd)) |
                    (uses_rs2 & (in_instr[24:20] == held_rd)));

   assign in_ready = ~flush & (~out_valid | out_ready) & ~hazard;
   assign load     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY,
            BUBBLE: state_d = load ? FULL : EMPTY;
            FULL: begin
               if (out_ready) begin
                  if (hazard)
                     state_d = BUBBLE;
                  else if (in_valid)
                     state_d = FULL;
                  else
                     state_d = EMPTY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         instr_q <= 32'h0;
         fmt_q   <= 8'h0;
      end else begin
         state_q <= state_d;
         if (load) begin
            instr_q <= in_instr;
            fmt_q   <= fmt_d;
         end
      end
   end

   assign out_instr         = instr_q;
   assign Rformat           = fmt_q[7];
   assign Iformat           = fmt_q[6];
   assign IbutnotSRAIformat = fmt_q[5];
   assign Sformat           = fmt_q[4];
   assign SBformat          = fmt_q[3];
   assign Uformat           = fmt_q[2];
   assign UJformat          = fmt_q[1];
   assign illegal           = fmt_q[0];

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bubble_inc;

   // A flush in the same cycle cancels the bubble, so it is not counted.
   assign bubble_inc = ~flush & (state_q == FULL) & out_ready & hazard;
   assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, bubble_inc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign bubble_cnt = cnt_q;
`else
   if (CNT_W > 0) begin : g_no_bubble_cnt
   end
`endif

endmodule
